// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending controller:
// coin encodings, FSM state type and denomination helpers.
package vm_pkg;

    localparam logic [1:0] COIN_1U  = 2'd0;
    localparam logic [1:0] COIN_2U  = 2'd1;
    localparam logic [1:0] COIN_5U  = 2'd2;
    localparam logic [1:0] COIN_10U = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vm_state_e;

    // Face value in credit units of a coin encoding.
    function automatic logic [4:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_1U:  return 5'd1;
            COIN_2U:  return 5'd2;
            COIN_5U:  return 5'd5;
            default:  return 5'd10;
        endcase
    endfunction

    // Largest denomination not exceeding the amount (1u when amount < 2).
    function automatic logic [1:0] largest_coin(input logic [31:0] amount);
        if (amount >= 32'd10)     return COIN_10U;
        else if (amount >= 32'd5) return COIN_5U;
        else if (amount >= 32'd2) return COIN_2U;
        else                      return COIN_1U;
    endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Combinational greedy change picker: credit in, coin type and its value out.
module vm_change_gen
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [1:0]          coin_o,
    output logic [4:0]          value_o
);

    // Pick the largest coin that fits in the remaining credit.
    always_comb begin
        coin_o  = largest_coin(32'(credit_i));
        value_o = coin_value(coin_o);
    end

endmodule

// File: rtl/vending_machine_mp.sv
// Multi-product vending controller: accumulates coin credit, vends items
// with per-item prices and stock, and pays change one coin per handshake.
module vending_machine_mp
    import vm_pkg::*;
#(
    parameter int unsigned            NUM_ITEMS  = 4,
    parameter int unsigned            CREDIT_W   = 6,
    parameter int unsigned            MAX_CREDIT = 40,
    parameter logic [NUM_ITEMS*8-1:0] PRICES     = {8'd10, 8'd7, 8'd5, 8'd3},
    parameter int unsigned            STOCK_W    = 4,
    parameter int unsigned            STOCK_INIT = 8,
    localparam int unsigned           SEL_W      = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_type,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    input  logic                 change_ready,
    output logic                 coin_reject,
    output logic                 vend_valid,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 err_pulse,
    output logic                 change_valid,
    output logic [1:0]           change_coin,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 busy
);

    vm_state_e             state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  err_q, err_d;
    logic [SEL_W-1:0]      vend_item_q, vend_item_d;

    logic [NUM_ITEMS-1:0]  stock_dec;
    logic [NUM_ITEMS-1:0]  empty;
    logic [1:0]            chg_coin;
    logic [4:0]            chg_value;
    logic                  item_ok;
    logic [SEL_W-1:0]      sel_idx;
    logic [CREDIT_W-1:0]   price;
    logic [CREDIT_W:0]     coin_sum;

    vm_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .credit_i (credit_q),
        .coin_o   (chg_coin),
        .value_o  (chg_value)
    );

    // Per-item stock counters; restock overrides a same-cycle decrement.
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_stock
        logic [STOCK_W-1:0] cnt_q;

        // Reload on reset/restock, otherwise count down on an accepted sale.
        always_ff @(posedge clk) begin
            if (rst || restock) begin
                cnt_q <= STOCK_W'(STOCK_INIT);
            end else if (stock_dec[i] && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign empty[i] = (cnt_q == '0);
    end

    // Selection decode and coin arithmetic feeding the FSM.
    always_comb begin
        item_ok  = (32'(sel_item) < NUM_ITEMS);
        sel_idx  = item_ok ? sel_item : '0;
        price    = CREDIT_W'(PRICES[8*sel_idx +: 8]);
        coin_sum = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(coin_value(coin_type));
    end

    // Next-state, credit and pulse logic.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;
        err_d         = 1'b0;
        vend_item_d   = vend_item_q;
        stock_dec     = '0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel && credit_q != '0) begin
                    state_d       = ST_CHANGE;
                    coin_reject_d = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (!item_ok || empty[sel_idx] || credit_q < price) begin
                        err_d = 1'b1;
                    end else begin
                        state_d            = ST_VEND;
                        credit_d           = credit_q - price;
                        stock_dec[sel_idx] = 1'b1;
                        vend_item_d        = sel_item;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    credit_d = credit_q - CREDIT_W'(chg_value);
                    if (credit_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, credit and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
            vend_item_q   <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
            err_q         <= err_d;
            vend_item_q   <= vend_item_d;
        end
    end

    assign coin_reject  = coin_reject_q;
    assign err_pulse    = err_q;
    assign vend_valid   = (state_q == ST_VEND);
    assign vend_item    = vend_item_q;
    assign change_valid = (state_q == ST_CHANGE);
    assign change_coin  = change_valid ? chg_coin : COIN_1U;
    assign credit       = credit_q;
    assign sold_out     = empty;
    assign busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vending_machine_mp.sv
// Directed bench for vending_machine_mp with default parameters
// (prices: item0=3, item1=5, item2=7, item3=10; stock 8; ceiling 40).
module tb_vending_machine_mp;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       restock;
    logic       change_ready;
    logic       coin_reject;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       err_pulse;
    logic       change_valid;
    logic [1:0] change_coin;
    logic [5:0] credit;
    logic [3:0] sold_out;
    logic       busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    vending_machine_mp dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .restock      (restock),
        .change_ready (change_ready),
        .coin_reject  (coin_reject),
        .vend_valid   (vend_valid),
        .vend_item    (vend_item),
        .err_pulse    (err_pulse),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .credit       (credit),
        .sold_out     (sold_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int cv, ct, sv, si, ca, cr;
        int rej, vv, vi, err, chv, chc, cred, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cv, input int ct, input int sv, input int si,
                                input int ca, input int cr, input int rej, input int vv,
                                input int vi, input int err, input int chv, input int chc,
                                input int cred, input int bsy);
        vec_t v;
        v.cv = cv; v.ct = ct; v.sv = sv; v.si = si; v.ca = ca; v.cr = cr;
        v.rej = rej; v.vv = vv; v.vi = vi; v.err = err; v.chv = chv; v.chc = chc;
        v.cred = cred; v.busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0; sel_item = 2'd0;
        cancel = 1'b0; restock = 1'b0; change_ready = 1'b0;
    endtask

    // Insert a 10u coin and buy item 3 (price 10), optionally with restock on the sale edge.
    task automatic sale3(input logic with_restock, input int k);
        coin_valid = 1'b1; coin_type = 2'd3;
        tick();
        coin_valid = 1'b0;
        sel_valid = 1'b1; sel_item = 2'd3; restock = with_restock;
        tick();
        sel_valid = 1'b0; restock = 1'b0;
        chk($sformatf("sale3_%0d vend_valid", k), 32'(vend_valid), 32'd1);
        chk($sformatf("sale3_%0d vend_item", k), 32'(vend_item), 32'd3);
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst credit", 32'(credit), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sold_out", 32'(sold_out), 32'd0);
        chk("rst change_valid", 32'(change_valid), 32'd0);
        chk("rst vend_valid", 32'(vend_valid), 32'd0);
        chk("rst change_coin", 32'(change_coin), 32'd0);
        chk("rst vend_item", 32'(vend_item), 32'd0);
        rst = 1'b0;

        //          cv ct sv si ca cr  rej vv vi er chv chc cred busy
        // basic sale: 2u + 5u, buy item 2 (7u)
        vecs.push_back(mk(1,1, 0,0, 0,0,  0,0,0,0, 0,0,  2,0));
        vecs.push_back(mk(1,2, 0,0, 0,0,  0,0,0,0, 0,0,  7,0));
        vecs.push_back(mk(0,0, 1,2, 0,0,  0,1,2,0, 0,0,  0,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0,0, 0,0,  0,0));
        // change: 10u, buy item 0 (3u), change 5u then 2u
        vecs.push_back(mk(1,3, 0,0, 0,1,  0,0,0,0, 0,0, 10,0));
        vecs.push_back(mk(0,0, 1,0, 0,1,  0,1,0,0, 0,0,  7,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,2,  7,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,1,  2,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 0,0,  0,0));
        // backpressure: buy item 1 (5u) from 10u, hopper stalls, coins rejected
        vecs.push_back(mk(1,3, 0,0, 0,0,  0,0,0,0, 0,0, 10,0));
        vecs.push_back(mk(0,0, 1,1, 0,0,  0,1,1,0, 0,0,  5,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0,0, 1,2,  5,1));
        vecs.push_back(mk(1,0, 0,0, 0,0,  1,0,0,0, 1,2,  5,1));
        vecs.push_back(mk(1,0, 1,0, 1,0,  1,0,0,0, 1,2,  5,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0,0, 1,2,  5,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 0,0,  0,0));
        // refusal: credit 4, item 1 costs 5
        vecs.push_back(mk(1,1, 0,0, 0,0,  0,0,0,0, 0,0,  2,0));
        vecs.push_back(mk(1,1, 0,0, 0,0,  0,0,0,0, 0,0,  4,0));
        vecs.push_back(mk(0,0, 1,1, 0,0,  0,0,0,1, 0,0,  4,0));
        vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0,0, 0,0,  4,0));
        // collision: sel item 0 with coin 10u, judged on credit 4, coin rejected
        vecs.push_back(mk(1,3, 1,0, 0,0,  1,1,0,0, 0,0,  1,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,0,  1,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 0,0,  0,0));
        // collision refused: credit 4, sel item 2 (7u) with 5u coin
        vecs.push_back(mk(1,1, 0,0, 0,0,  0,0,0,0, 0,0,  2,0));
        vecs.push_back(mk(1,1, 0,0, 0,0,  0,0,0,0, 0,0,  4,0));
        vecs.push_back(mk(1,2, 1,2, 0,0,  1,0,0,1, 0,0,  4,0));
        // cancel refunds 4 as 2u + 2u
        vecs.push_back(mk(0,0, 0,0, 1,0,  0,0,0,0, 1,1,  4,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,1,  2,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 0,0,  0,0));
        // cancel with zero credit does nothing
        vecs.push_back(mk(0,0, 0,0, 1,0,  0,0,0,0, 0,0,  0,0));
        // ceiling: 35 + 10 rejected, exactly 40 accepted, 40 + 1 rejected
        vecs.push_back(mk(1,3, 0,0, 0,0,  0,0,0,0, 0,0, 10,0));
        vecs.push_back(mk(1,3, 0,0, 0,0,  0,0,0,0, 0,0, 20,0));
        vecs.push_back(mk(1,3, 0,0, 0,0,  0,0,0,0, 0,0, 30,0));
        vecs.push_back(mk(1,2, 0,0, 0,0,  0,0,0,0, 0,0, 35,0));
        vecs.push_back(mk(1,3, 0,0, 0,0,  1,0,0,0, 0,0, 35,0));
        vecs.push_back(mk(1,2, 0,0, 0,0,  0,0,0,0, 0,0, 40,0));
        vecs.push_back(mk(1,0, 0,0, 0,0,  1,0,0,0, 0,0, 40,0));
        vecs.push_back(mk(0,0, 0,0, 1,0,  0,0,0,0, 1,3, 40,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,3, 30,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,3, 20,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 1,3, 10,1));
        vecs.push_back(mk(0,0, 0,0, 0,1,  0,0,0,0, 0,0,  0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            coin_valid   = vecs[i].cv[0];
            coin_type    = vecs[i].ct[1:0];
            sel_valid    = vecs[i].sv[0];
            sel_item     = vecs[i].si[1:0];
            cancel       = vecs[i].ca[0];
            change_ready = vecs[i].cr[0];
            restock      = 1'b0;
            tick();
            chk($sformatf("v%0d coin_reject", i), 32'(coin_reject), vecs[i].rej);
            chk($sformatf("v%0d vend_valid", i), 32'(vend_valid), vecs[i].vv);
            if (vecs[i].vv != 0)
                chk($sformatf("v%0d vend_item", i), 32'(vend_item), vecs[i].vi);
            chk($sformatf("v%0d err_pulse", i), 32'(err_pulse), vecs[i].err);
            chk($sformatf("v%0d change_valid", i), 32'(change_valid), vecs[i].chv);
            if (vecs[i].chv != 0)
                chk($sformatf("v%0d change_coin", i), 32'(change_coin), vecs[i].chc);
            chk($sformatf("v%0d credit", i), 32'(credit), vecs[i].cred);
            chk($sformatf("v%0d busy", i), 32'(busy), vecs[i].busy);
        end
        clear_inputs();

        // Drain item 3: sold_out[3] rises exactly on the 8th sale
        for (int k = 1; k <= 8; k++) begin
            sale3(1'b0, k);
            chk($sformatf("drain%0d sold_out3", k), 32'(sold_out[3]), (k == 8) ? 32'd1 : 32'd0);
        end
        chk("drain sold_out others", 32'(sold_out[2:0]), 32'd0);

        // Sold-out item refused, credit kept
        coin_valid = 1'b1; coin_type = 2'd3;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b1; sel_item = 2'd3;
        tick();
        sel_valid = 1'b0;
        chk("soldout err_pulse", 32'(err_pulse), 32'd1);
        chk("soldout vend_valid", 32'(vend_valid), 32'd0);
        chk("soldout credit", 32'(credit), 32'd10);

        // Restock while holding credit, then buy
        restock = 1'b1;
        tick();
        restock = 1'b0;
        chk("restock sold_out", 32'(sold_out), 32'd0);
        chk("restock credit", 32'(credit), 32'd10);
        sel_valid = 1'b1; sel_item = 2'd3;
        tick();
        sel_valid = 1'b0;
        chk("restock sale vend_valid", 32'(vend_valid), 32'd1);
        tick();
        // stock 7 -> 1
        for (int k = 0; k < 6; k++) sale3(1'b0, 10 + k);
        chk("stock1 sold_out3", 32'(sold_out[3]), 32'd0);
        // last unit sold with restock on the same edge: restock wins -> 8
        sale3(1'b1, 20);
        chk("restock_vs_vend sold_out3", 32'(sold_out[3]), 32'd0);
        for (int k = 0; k < 7; k++) sale3(1'b0, 30 + k);
        chk("after7 sold_out3", 32'(sold_out[3]), 32'd0);
        sale3(1'b0, 40);
        chk("after8 sold_out3", 32'(sold_out[3]), 32'd1);

        // Cancel credit 6 -> 5u then 1u, reset mid-change
        coin_valid = 1'b1; coin_type = 2'd2;
        tick();
        coin_type = 2'd0;
        tick();
        coin_valid = 1'b0;
        chk("cancel6 credit", 32'(credit), 32'd6);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel6 change_valid", 32'(change_valid), 32'd1);
        chk("cancel6 change_coin", 32'(change_coin), 32'd2);
        chk("cancel6 busy", 32'(busy), 32'd1);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        chk("cancel6 credit after 5u", 32'(credit), 32'd1);
        chk("cancel6 change_coin 1u", 32'(change_coin), 32'd0);
        chk("cancel6 still valid", 32'(change_valid), 32'd1);
        rst = 1'b1;
        change_ready = 1'b1;
        tick();
        rst = 1'b0;
        change_ready = 1'b0;
        chk("midrst change_valid", 32'(change_valid), 32'd0);
        chk("midrst credit", 32'(credit), 32'd0);
        chk("midrst sold_out", 32'(sold_out), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        tick();
        chk("postrst change_valid", 32'(change_valid), 32'd0);
        chk("postrst credit", 32'(credit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
